ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset)
//  to the keyboard over the same PS2_CLK/PS2_DATA pair our keyboard receiver listens on.
//  Drives both lines open-drain (pull-low enables only), runs the inhibit/request-to-send
//  sequence, shifts data on device clock falling edges, and checks the device ACK.
//  TX_BUSY gates the keyboard receiver so it ignores host-generated traffic.
// PARAMETERS
//  INHIBIT_CYCLES       5000     CLK cycles PS2_CLK held low before RTS (100 us @ 50 MHz)
//  START_TIMEOUT_CYCLES 750000   max wait for first device falling edge (15 ms @ 50 MHz)
//  XFER_TIMEOUT_CYCLES  100000   max time from first falling edge to ACK (2 ms @ 50 MHz)
// PORTS
//  CLK          in   1  board clock
//  RESET_N      in   1  async active-low reset
//  TX_DATA      in   8  byte to send; sampled on the cycle TX_START is accepted
//  TX_START     in   1  1-cycle request; accepted only in IDLE, ignored otherwise
//  PS2_CLK_IN   in   1  PS/2 clock pin level (async, wired-AND bus)
//  PS2_DATA_IN  in   1  PS/2 data pin level (async)
//  PS2_CLK_OE   out  1  1 = pull PS2_CLK low; 0 = release (pull-up gives 1)
//  PS2_DATA_OE  out  1  1 = pull PS2_DATA low; 0 = release
//  TX_BUSY      out  1  1 from accept cycle until TX_DONE cycle inclusive
//  TX_DONE      out  1  1-cycle pulse at end of every accepted transfer
//  TX_ERR       out  1  valid with TX_DONE: 1 = timeout or no ACK; 0 = ACKed
// BEHAVIOUR
//  Reset: all outputs 0 (both lines released), state IDLE, counters 0. Async assert drops
//   OEs immediately; synchronous release. Reset mid-transfer aborts with no TX_DONE.
//  PS2_CLK_IN/PS2_DATA_IN each pass a 2-FF synchronizer; falling edge = prev 1, now 0 on
//   synchronized clock (edge flag 3 CLK after pin). All OE outputs are registered.
//  Frame: start 0, D0..D7 LSB first, odd parity P = ~^TX_DATA, stop 1 (release), ACK.
//  FSM:
//   IDLE    : OEs 0. TX_START -> latch TX_DATA, build shift reg, TX_BUSY=1 -> INHIBIT.
//   INHIBIT : CLK_OE=1, DATA_OE=0 for INHIBIT_CYCLES cycles -> RTS.
//   RTS     : CLK_OE=1, DATA_OE=1 for exactly 1 cycle -> WAIT_CLK.
//   WAIT_CLK: CLK_OE=0, DATA_OE=1 (start bit). Start counter runs; falling edge ->
//             drive D0 (edge 1), bit index=1, start xfer counter -> SHIFT.
//             START_TIMEOUT_CYCLES reached with no edge -> FAIL.
//   SHIFT   : on falling edge k (k=2..10) drive bit k-1: D1..D7, P, stop. Driving 0 ->
//             DATA_OE=1; driving 1 -> DATA_OE=0. After edge 10 (stop) -> ACK.
//   ACK     : DATA_OE=0; on falling edge 11 sample synchronized data: 0 -> OK, 1 -> FAIL.
//   OK/FAIL : one cycle, OEs 0, TX_DONE=1, TX_ERR=0/1 -> IDLE (TX_BUSY drops next cycle).
//  Xfer counter runs in SHIFT and ACK; reaching XFER_TIMEOUT_CYCLES -> FAIL (OEs released).
//  Counters saturate-free: sized ceil(log2(max param)+1); compare with >=, reset on entry.
//  TX_START coincident with TX_DONE is ignored (FSM not yet in IDLE).
//  Glitch on PS2_CLK_IN in INHIBIT/RTS (host driving low) is ignored: edges only in
//   WAIT_CLK/SHIFT/ACK. Data line changes only while device clock low (edge-driven).
// TESTING
//  T1 TX_DATA=8'hED, device model clocks 11 pulses @ 12 kHz, ACKs low -> CLK_OE high 5000 cyc,
//     captured bits 1,0,1,1,0,1,1,1, P=1, stop=1; TX_DONE=1 TX_ERR=0; BUSY throughout.
//  T2 TX_DATA=8'h01 and 8'hFF -> P=0 and P=1 respectively; both ACKed, TX_ERR=0.
//  T3 device never clocks -> 750000 cyc after RTS: TX_DONE=1 TX_ERR=1, both OEs 0.
//  T4 device leaves data high at edge 11 -> TX_DONE=1 TX_ERR=1.
//  T5 device stops after edge 5 -> 100000 cyc after edge 1: TX_DONE=1 TX_ERR=1, OEs 0.
//  T6 RESET_N low during SHIFT -> OEs/BUSY 0 without waiting for CLK, no TX_DONE;
//     TX_START pulsed while BUSY -> ignored, single frame on the wire.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard over the shared open-drain PS2_CLK /
// PS2_DATA pair. The host inhibits the bus, issues request-to-send, then changes
// data on each device-generated falling clock edge and finally checks the ACK bit.
// Both pins are only ever pulled low (OE=1) or released (OE=0).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TX_ERR
);

    // One shared cycle counter serves inhibit, start wait and transfer timeout,
    // so it is sized for the largest of the three limits.
    localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                             INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > XFER_TIMEOUT_CYCLES) ? MAX_AB : XFER_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1) + 1;

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 1);

    // Index of the last frame bit (stop) driven before the ACK phase.
    localparam logic [3:0] STOP_IDX = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_WAIT_CLK,
        S_SHIFT,
        S_ACK,
        S_OK,
        S_FAIL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [9:0]       frame_sr;

    logic ps2_clk_p0;
    logic ps2_clk_p1;
    logic ps2_clk_p2;
    logic ps2_data_p0;
    logic ps2_data_p1;
    logic clk_fall;
    logic accept;
    logic shift_en;

    // Odd parity bit: set when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame as it goes on the wire after the start bit: D0..D7, parity, stop.
    function automatic logic [9:0] build_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d};
    endfunction

    // Two-flop synchronizers for both pins plus a delayed clock copy for edge detect.
    // The bus idles high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_clk_p2  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            // stage p0: first capture of the asynchronous pins
            ps2_clk_p0  <= PS2_CLK_IN;
            ps2_data_p0 <= PS2_DATA_IN;
            // stage p1: metastability-settled levels
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_data_p1 <= ps2_data_p0;
            // stage p2: previous settled clock level for edge detection
            ps2_clk_p2  <= ps2_clk_p1;
        end
    end

    assign clk_fall = ps2_clk_p2 & ~ps2_clk_p1;
    assign accept   = (state == S_IDLE) && TX_START;
    assign shift_en = clk_fall && ((state == S_WAIT_CLK) || (state == S_SHIFT));

    // Frame shift register: loaded on accept, advanced once per driven bit.
    // It carries only data, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            frame_sr <= build_frame(TX_DATA);
        end else if (shift_en) begin
            frame_sr <= {1'b0, frame_sr[9:1]};
        end
    end

    // Transmit sequencer with registered pin enables and status outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
            TX_BUSY     <= 1'b0;
            TX_DONE     <= 1'b0;
            TX_ERR      <= 1'b0;
        end else begin
            TX_DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    TX_ERR      <= 1'b0;
                    if (TX_START) begin
                        TX_BUSY    <= 1'b1;
                        PS2_CLK_OE <= 1'b1;
                        cnt        <= '0;
                        state      <= S_INHIBIT;
                    end
                end

                // Hold the clock low so the device aborts anything it was sending.
                S_INHIBIT: begin
                    if (cnt >= INH_LAST) begin
                        PS2_DATA_OE <= 1'b1;
                        state       <= S_RTS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Clock and data both low for one cycle, then release the clock
                // while keeping data low: that low data is the start bit.
                S_RTS: begin
                    PS2_CLK_OE <= 1'b0;
                    cnt        <= '0;
                    state      <= S_WAIT_CLK;
                end

                S_WAIT_CLK: begin
                    if (clk_fall) begin
                        PS2_DATA_OE <= ~frame_sr[0];
                        bit_idx     <= 4'd1;
                        cnt         <= '0;
                        state       <= S_SHIFT;
                    end else if (cnt >= START_LAST) begin
                        PS2_DATA_OE <= 1'b0;
                        TX_DONE     <= 1'b1;
                        TX_ERR      <= 1'b1;
                        state       <= S_FAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Data changes only right after a falling edge, while the device
                // holds its clock low; the device samples on the rising edge.
                S_SHIFT: begin
                    if (cnt >= XFER_LAST) begin
                        PS2_DATA_OE <= 1'b0;
                        TX_DONE     <= 1'b1;
                        TX_ERR      <= 1'b1;
                        state       <= S_FAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (clk_fall) begin
                            PS2_DATA_OE <= ~frame_sr[0];
                            bit_idx     <= bit_idx + 1'b1;
                            if (bit_idx == STOP_IDX) begin
                                state <= S_ACK;
                            end
                        end
                    end
                end

                // Data is released; the device pulls it low on edge 11 to acknowledge.
                S_ACK: begin
                    PS2_DATA_OE <= 1'b0;
                    if (cnt >= XFER_LAST) begin
                        TX_DONE <= 1'b1;
                        TX_ERR  <= 1'b1;
                        state   <= S_FAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (clk_fall) begin
                            TX_DONE <= 1'b1;
                            TX_ERR  <= ps2_data_p1;
                            state   <= ps2_data_p1 ? S_FAIL : S_OK;
                        end
                    end
                end

                // Completion cycle: TX_DONE is high here; busy drops on the way out.
                S_OK, S_FAIL: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    TX_BUSY     <= 1'b0;
                    cnt         <= '0;
                    bit_idx     <= '0;
                    state       <= S_IDLE;
                end

                default: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    TX_BUSY     <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
